// File: rtl/cs_enc_sched.sv
// Round-robin scheduler sharing one encoder port among NREQ requesters, results returned in order.
// Define CS_SCHED_STATS_EN to build the stat_jobs / stat_nocredit counters.
module cs_enc_sched #(
  parameter int unsigned K     = 5,
  parameter int unsigned M     = 3,
  parameter int unsigned L     = 11,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*M*(L-1)-1:0] req_data,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [K*(L-1)-1:0]      rsp_data,
  output logic                    enc_in_valid,
  input  logic                    enc_in_ready,
  output logic [M*(L-1)-1:0]      enc_din,
  input  logic                    enc_out_valid,
  input  logic [K*(L-1)-1:0]      enc_dout,
`ifdef CS_SCHED_STATS_EN
  output logic [31:0]             stat_jobs [NREQ],
  output logic [31:0]             stat_nocredit,
`endif
  output logic                    err_orphan
);

  localparam int unsigned DinW  = M * (L - 1);
  localparam int unsigned DoutW = K * (L - 1);
  localparam int unsigned TagW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned ResW  = TagW + DoutW;

  typedef enum logic [0:0] {StEmpty, StHold} issue_st_e;

  issue_st_e         issue_q;
  logic [DinW-1:0]   din_q;
  logic [TagW-1:0]   tag_q;
  logic [TagW-1:0]   rr_ptr_q;
  logic [CntW-1:0]   credits_q;

  logic [DinW-1:0]   req_blk [NREQ];
  logic              can_grant;
  logic              grant_valid;
  logic [TagW-1:0]   grant_idx;
  logic [TagW-1:0]   scan_idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_blk
    assign req_blk[g] = req_data[g*DinW +: DinW];
  end

  assign enc_in_valid = (issue_q == StHold);
  assign enc_din      = din_q;

  // Gated by aresetn so nothing is accepted during the reset cycle and then lost.
  assign can_grant = aresetn && (credits_q != '0) && ((issue_q == StEmpty) || enc_in_ready);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = TagW'((32'(rr_ptr_q) + i) % NREQ);
      if (can_grant && !grant_valid && req_valid[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    req_ready = '0;
    if (grant_valid) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      issue_q  <= StEmpty;
      din_q    <= '0;
      tag_q    <= '0;
      rr_ptr_q <= '0;
    end else if (grant_valid) begin
      issue_q  <= StHold;
      din_q    <= req_blk[grant_idx];
      tag_q    <= grant_idx;
      rr_ptr_q <= (grant_idx == TagW'(NREQ - 1)) ? '0 : grant_idx + TagW'(1);
    end else if ((issue_q == StHold) && enc_in_ready) begin
      issue_q <= StEmpty;
    end
  end

  // Tag FIFO: IDs of jobs accepted by the encoder, awaiting their result strobe.
  logic [TagW-1:0] tag_mem [DEPTH];
  logic [PtrW-1:0] tag_wr_q, tag_rd_q;
  logic [CntW-1:0] tag_cnt_q;
  logic            tag_push, tag_pop, tag_empty;

  assign tag_push  = enc_in_valid && enc_in_ready;
  assign tag_empty = (tag_cnt_q == '0);
  assign tag_pop   = enc_out_valid && !tag_empty;

  always_ff @(posedge aclk) begin
    if (tag_push) tag_mem[tag_wr_q] <= tag_q;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
    end else begin
      if (tag_push) tag_wr_q <= tag_wr_q + PtrW'(1);
      if (tag_pop)  tag_rd_q <= tag_rd_q + PtrW'(1);
      tag_cnt_q <= tag_cnt_q + CntW'(tag_push) - CntW'(tag_pop);
    end
  end

  // Result FIFO: {tag, coded block}; the head is presented straight from storage.
  logic [ResW-1:0] res_mem [DEPTH];
  logic [PtrW-1:0] res_wr_q, res_rd_q;
  logic [CntW-1:0] res_cnt_q;
  logic [ResW-1:0] res_head;
  logic [TagW-1:0] head_tag;
  logic            res_empty, rsp_hs;

  assign res_empty = (res_cnt_q == '0);
  assign res_head  = res_mem[res_rd_q];
  assign head_tag  = res_head[ResW-1:DoutW];
  assign rsp_hs    = !res_empty && rsp_ready[head_tag];
  assign rsp_data  = res_empty ? '0 : res_head[DoutW-1:0];

  always_comb begin
    rsp_valid = '0;
    if (!res_empty) rsp_valid[head_tag] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (tag_pop) res_mem[res_wr_q] <= {tag_mem[tag_rd_q], enc_dout};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      res_wr_q  <= '0;
      res_rd_q  <= '0;
      res_cnt_q <= '0;
    end else begin
      if (tag_pop) res_wr_q <= res_wr_q + PtrW'(1);
      if (rsp_hs)  res_rd_q <= res_rd_q + PtrW'(1);
      res_cnt_q <= res_cnt_q + CntW'(tag_pop) - CntW'(rsp_hs);
    end
  end

  // Credits cover the issue register, the encoder pipeline and the result FIFO.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      credits_q  <= CntW'(DEPTH);
      err_orphan <= 1'b0;
    end else begin
      case ({grant_valid, rsp_hs})
        2'b10:   credits_q <= credits_q - CntW'(1);
        2'b01:   credits_q <= credits_q + CntW'(1);
        default: credits_q <= credits_q;
      endcase
      if (enc_out_valid && tag_empty) err_orphan <= 1'b1;
    end
  end

`ifdef CS_SCHED_STATS_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < NREQ; i++) stat_jobs[i] <= '0;
      stat_nocredit <= '0;
    end else begin
      if (rsp_hs) stat_jobs[head_tag] <= stat_jobs[head_tag] + 32'd1;
      if ((|req_valid) && (credits_q == '0) && (stat_nocredit != '1)) begin
        stat_nocredit <= stat_nocredit + 32'd1;
      end
    end
  end
`endif

endmodule
